pipe_hazard_tracker: RTL

- Parametrised data-hazard tracker and forwarding controller for the decode stage.
- Generalises the fixed EX/MEM forwarding and single load-use interlock to a configurable load latency and N in-flight destination stages.
- Keeps its own shadow pipeline of in-flight writers (dst, wreg, m2reg). Replaces decode-side combinational compares against individual stage signals.
- Drives per-source forwarding selects, the PC/IF-ID write enable (wpcir) and the bubble-insert control for EX.

---
 rtl/pipe_hazard_tracker_if.sv | 35 +++
 rtl/pipe_hazard_tracker.sv | 111 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_tracker_if.sv
// Decode-side bundle for the hazard tracker: instruction fields from ID,
// the memory-side hold, and the stall/forwarding controls sent back to ID/EX.
// master = decode stage (drives id_* and mem_hold), slave = tracker.
interface pipe_hazard_tracker_if #(
    parameter int AW   = 5,
    parameter int SELW = 3
);
    logic            id_valid;
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_wreg;
    logic            id_m2reg;
    logic [AW-1:0]   id_rn;
    logic            mem_hold;
    logic            wpcir;
    logic            ex_bubble;
    logic [SELW-1:0] fwda_sel;
    logic [SELW-1:0] fwdb_sel;
    logic            fwda_load;
    logic            fwdb_load;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rn, mem_hold,
        input  wpcir, ex_bubble, fwda_sel, fwdb_sel, fwda_load, fwdb_load
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rn, mem_hold,
        output wpcir, ex_bubble, fwda_sel, fwdb_sel, fwda_load, fwdb_load
    );
endinterface

// File: rtl/pipe_hazard_tracker.sv
// Data-hazard tracker and forwarding controller for the decode stage.
// Keeps a shadow pipeline of in-flight writers (EX, MEM1..MEMn, WB) and from it
// derives per-source forwarding selects, the load-use interlock (wpcir) and
// the EX bubble request. The youngest matching writer always wins.
// Optional feature macro: HAZARD_STATS_EN adds stall_cnt / fwd_cnt counters.
module pipe_hazard_tracker #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int D        = LOAD_LAT + 2,
    parameter int SELW     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    pipe_hazard_tracker_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          fwd_cnt
`endif
);

    // Shadow pipeline: index 0 = EX, 1..LOAD_LAT = memory stages, D-1 = WB
    logic [D-1:0]  ent_valid;
    logic [D-1:0]  ent_wreg;
    logic [D-1:0]  ent_m2reg;
    logic [AW-1:0] ent_rn [D];

    logic [SELW-1:0] sel_a, sel_b;
    logic            load_a, load_b;
    logic            early_a, early_b;
    logic            hazard;
    logic            stall;

    // Youngest-match search per source; scanning oldest to youngest lets the lowest index overwrite
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        early_a = 1'b0;
        early_b = 1'b0;
        for (int k = D - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_wreg[k] && bus.id_valid &&
                bus.id_use_rs && (bus.id_rs != '0) && (ent_rn[k] == bus.id_rs)) begin
                sel_a   = SELW'(k + 1);
                load_a  = ent_m2reg[k];
                early_a = ent_m2reg[k] && (k < LOAD_LAT);
            end
            if (ent_valid[k] && ent_wreg[k] && bus.id_valid &&
                bus.id_use_rt && (bus.id_rt != '0) && (ent_rn[k] == bus.id_rt)) begin
                sel_b   = SELW'(k + 1);
                load_b  = ent_m2reg[k];
                early_b = ent_m2reg[k] && (k < LOAD_LAT);
            end
        end
    end

    // A load whose data is not yet out of memory forces an interlock; mem_hold stalls everything
    always_comb begin
        hazard = early_a | early_b;
        stall  = hazard | bus.mem_hold;
    end

    assign bus.wpcir     = ~stall;
    assign bus.ex_bubble = hazard & ~bus.mem_hold;
    assign bus.fwda_sel  = sel_a;
    assign bus.fwdb_sel  = sel_b;
    assign bus.fwda_load = load_a;
    assign bus.fwdb_load = load_b;

    // Advance the shadow pipeline unless memory holds; a hazard injects an invalid bubble into EX
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_wreg  <= '0;
            ent_m2reg <= '0;
            for (int k = 0; k < D; k++) begin
                ent_rn[k] <= '0;
            end
        end else if (!bus.mem_hold) begin
            for (int k = D - 1; k >= 1; k--) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wreg[k]  <= ent_wreg[k-1];
                ent_m2reg[k] <= ent_m2reg[k-1];
                ent_rn[k]    <= ent_rn[k-1];
            end
            ent_valid[0] <= bus.id_valid & ~hazard;
            ent_wreg[0]  <= bus.id_wreg;
            ent_m2reg[0] <= bus.id_m2reg;
            ent_rn[0]    <= bus.id_rn;
        end
    end

`ifdef HAZARD_STATS_EN
    // Count interlock cycles (held cycles excluded) and issuing cycles that used any forward path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (hazard && !bus.mem_hold) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!stall && ((sel_a != '0) || (sel_b != '0))) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
